// File: rtl/seg7_pkg.sv
// Shared definitions for the 8-digit 7-segment scan driver: FSM state type,
// all-off constants and the hex-to-segment lookup (segments {a..g}, active low).
package seg7_pkg;

   typedef enum logic [1:0] {
      S_OFF   = 2'd0,
      S_GUARD = 2'd1,
      S_SHOW  = 2'd2
   } seg7_state_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [7:0] AN_OFF  = 8'hFF;

   function automatic logic [6:0] seg7_hex2seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'b0000001;
         4'h1:    seg = 7'b1001111;
         4'h2:    seg = 7'b0010010;
         4'h3:    seg = 7'b0000110;
         4'h4:    seg = 7'b1001100;
         4'h5:    seg = 7'b0100100;
         4'h6:    seg = 7'b0100000;
         4'h7:    seg = 7'b0001111;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0000100;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b1100000;
         4'hC:    seg = 7'b0110001;
         4'hD:    seg = 7'b1000010;
         4'hE:    seg = 7'b0110000;
         default: seg = 7'b0111000;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// Loadable down-counter timing one FSM slot. Loading N makes `done` assert
// during the (N+1)-th cycle after the load edge.
module seg7_tick_gen #(
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk,
   input  logic             Rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             done
);

   logic [WIDTH-1:0] count_q;

   // Count down to zero and park there until the next load.
   always_ff @(posedge clk) begin
      if (Rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (count_q != '0) begin
         count_q <= count_q - WIDTH'(1);
      end
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// The display word is snapshotted once per frame; an all-off guard slot precedes
// each digit. Outputs are registered from next-state values (no input->output paths).
// Optional feature: define SEG7_LZ_BLANK_EN for leading-zero suppression.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned TICKS_PER_DIGIT = 100000,
   parameter int unsigned GUARD_CYCLES    = 16
) (
   input  logic        clk,
   input  logic        Rst,
   input  logic [31:0] value,
   input  logic        hold,
   input  logic        blank,
   output logic [7:0]  an,
   output logic [6:0]  sev_out,
   output logic        frame_done
);

   localparam int unsigned MaxTg  = (TICKS_PER_DIGIT > GUARD_CYCLES) ? TICKS_PER_DIGIT
                                                                      : GUARD_CYCLES;
   localparam int unsigned MaxDur = (MaxTg > 2) ? MaxTg : 2;
   localparam int unsigned CntW   = $clog2(MaxDur);

   localparam logic [CntW-1:0] ShowLoad  = CntW'(TICKS_PER_DIGIT - 1);
   localparam logic [CntW-1:0] GuardLoad = CntW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
   // Slot that starts every digit: guard if configured, else straight to show.
   localparam seg7_state_t SlotStart = (GUARD_CYCLES == 0) ? S_SHOW : S_GUARD;

   seg7_state_t     state_q, state_d;
   logic [2:0]      digit_q, digit_d;
   logic [31:0]     snap_q, snap_d;
   logic [7:0]      an_q, an_d;
   logic [6:0]      sev_q, sev_d;
   logic            frame_done_q, frame_done_d;
   logic            tick_done, tick_load;
   logic [CntW-1:0] tick_val;
   logic            lit;

`ifdef SEG7_LZ_BLANK_EN
   // Index of the highest nonzero nibble; 0 for an all-zero word.
   function automatic logic [2:0] lead_idx(input logic [31:0] w);
      logic [2:0] h;
      h = '0;
      for (int k = 1; k < 8; k++) begin
         if (w[4*k +: 4] != 4'h0) h = 3'(k);
      end
      return h;
   endfunction
`endif

   seg7_tick_gen #(
      .WIDTH (CntW)
   ) u_tick (
      .clk      (clk),
      .Rst      (Rst),
      .load     (tick_load),
      .load_val (tick_val),
      .done     (tick_done)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (Rst) state_q <= S_OFF;
      else     state_q <= state_d;
   end

   // Next-state, digit sequencing and frame snapshot.
   always_comb begin
      state_d      = state_q;
      digit_d      = digit_q;
      snap_d       = snap_q;
      frame_done_d = 1'b0;
      if (blank) begin
         state_d = S_OFF;
         digit_d = '0;
      end else begin
         unique case (state_q)
            S_OFF: begin
               state_d = SlotStart;
               digit_d = '0;
               snap_d  = value;
            end
            S_GUARD: begin
               if (tick_done) state_d = S_SHOW;
            end
            S_SHOW: begin
               if (tick_done) begin
                  state_d = SlotStart;
                  if (digit_q == 3'd7) begin
                     digit_d      = '0;
                     frame_done_d = 1'b1;
                     if (!hold) snap_d = value;
                  end else begin
                     digit_d = digit_q + 3'd1;
                  end
               end
            end
            default: state_d = S_OFF;
         endcase
      end
   end

   // Slot timer reload on every state change and at each slot end (covers show->show).
   always_comb begin
      tick_load = (state_d != state_q) || tick_done;
      unique case (state_d)
         S_GUARD: tick_val = GuardLoad;
         S_SHOW:  tick_val = ShowLoad;
         default: tick_val = '0;
      endcase
   end

   // Output decode from next-state values so the registered outputs track the state.
   always_comb begin
      an_d  = AN_OFF;
      sev_d = SEG_OFF;
      lit   = 1'b1;
`ifdef SEG7_LZ_BLANK_EN
      lit   = (digit_d <= lead_idx(snap_d));
`endif
      unique case (state_d)
         S_GUARD: begin
            // Pre-drive segments for the upcoming digit while anodes are off.
            if (lit) sev_d = seg7_hex2seg(snap_d[{digit_d, 2'b00} +: 4]);
         end
         S_SHOW: begin
            if (lit) begin
               an_d  = ~(8'b1 << digit_d);
               sev_d = seg7_hex2seg(snap_d[{digit_d, 2'b00} +: 4]);
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (Rst) begin
         digit_q      <= '0;
         snap_q       <= value;
         an_q         <= AN_OFF;
         sev_q        <= SEG_OFF;
         frame_done_q <= 1'b0;
      end else begin
         digit_q      <= digit_d;
         snap_q       <= snap_d;
         an_q         <= an_d;
         sev_q        <= sev_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign an         = an_q;
   assign sev_out    = sev_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with TICKS_PER_DIGIT=4, GUARD_CYCLES=1
// (40-cycle frame). Define SEG7_LZ_BLANK_EN for both files to check suppression.
module tb_seg7_scan_driver;

   logic        clk;
   logic        Rst;
   logic [31:0] value;
   logic        hold;
   logic        blank;
   logic [7:0]  an;
   logic [6:0]  sev_out;
   logic        frame_done;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [6:0] S0 = 7'b0000001;
   localparam logic [6:0] S1 = 7'b1001111;
   localparam logic [6:0] S2 = 7'b0010010;
   localparam logic [6:0] S4 = 7'b1001100;
   localparam logic [6:0] S5 = 7'b0100100;
   localparam logic [6:0] S7 = 7'b0001111;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] SA = 7'b0001000;
   localparam logic [6:0] SD = 7'b1000010;
   localparam logic [6:0] SE = 7'b0110000;
   localparam logic [6:0] SF = 7'b0111000;

   seg7_scan_driver #(
      .TICKS_PER_DIGIT (4),
      .GUARD_CYCLES    (1)
   ) dut (
      .clk        (clk),
      .Rst        (Rst),
      .value      (value),
      .hold       (hold),
      .blank      (blank),
      .an         (an),
      .sev_out    (sev_out),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_out(input string tag, input logic [7:0] exp_an, input logic [6:0] exp_sev);
      check_eq({tag, "_an"}, {24'h0, an}, {24'h0, exp_an});
      check_eq({tag, "_sev"}, {25'h0, sev_out}, {25'h0, exp_sev});
   endtask

   initial begin
      int fd_cnt;
      Rst   = 1'b1;
      value = 32'h89ABCDEF;
      hold  = 1'b0;
      blank = 1'b0;

      // 1. reset, then first frame
      step(2);
      check_out("reset", 8'hFF, 7'h7F);
      check_eq("reset_fd", {31'h0, frame_done}, 32'h0);
      Rst = 1'b0;
      step();
      check_out("t1_guard0", 8'hFF, SF);
      for (int s = 0; s < 4; s++) begin
         step();
         check_out("t1_show0", 8'hFE, SF);
      end
      step();
      check_out("t1_guard1", 8'hFF, SE);
      step();
      check_out("t1_show1", 8'hFD, SE);
      fd_cnt = 0;
      for (int s = 6; s <= 38; s++) begin
         step();
         if (frame_done) fd_cnt++;
      end
      check_eq("t1_no_early_fd", fd_cnt, 0);
      step();
      check_eq("t1_fd", {31'h0, frame_done}, 32'h1);
      check_out("t1_fd_slot", 8'hFF, SF);
      step();
      check_out("t1_next_show0", 8'hFE, SF);
      check_eq("t1_fd_oneshot", {31'h0, frame_done}, 32'h0);

      // 2. mid-frame value change invisible until the next snapshot (now r=1)
      step(9);
      value = 32'h01234567;
      step();
      check_out("t2_d2_old", 8'hFB, SD);
      step(25);
      check_out("t2_d7_old", 8'h7F, S8);
      step(4);
      check_eq("t2_fd", {31'h0, frame_done}, 32'h1);
      check_out("t2_predrive", 8'hFF, S7);
      step();
      check_out("t2_new_d0", 8'hFE, S7);

      // 3. hold across a frame boundary
      hold  = 1'b1;
      value = 32'h11111111;
      step(39);
      check_eq("t3_fd_hold", {31'h0, frame_done}, 32'h1);
      step();
      check_out("t3_held_d0", 8'hFE, S7);
      hold = 1'b0;
      step(39);
      check_eq("t3_fd_release", {31'h0, frame_done}, 32'h1);
      step();
      check_out("t3_new_d0", 8'hFE, S1);

      // 4. blank while digit 3 is shown
      step(15);
      check_out("t4_d3", 8'hF7, S1);
      value = 32'h00000042;
      blank = 1'b1;
      step();
      check_out("t4_blank", 8'hFF, 7'h7F);
      check_eq("t4_blank_fd", {31'h0, frame_done}, 32'h0);
      step(3);
      check_out("t4_blank_hold", 8'hFF, 7'h7F);
      blank = 1'b0;
      step();
      check_out("t4_restart_guard", 8'hFF, S2);
      fd_cnt = 0;
      for (int i = 1; i <= 39; i++) begin
         step();
         if (frame_done) fd_cnt++;
         if (i == 1) check_out("t4_restart_d0", 8'hFE, S2);
         if (i == 6) check_out("t4_restart_d1", 8'hFD, S4);
      end
      check_eq("t4_no_spurious_fd", fd_cnt, 0);
      step();
      check_eq("t4_fd", {31'h0, frame_done}, 32'h1);

      // 5. reset in the middle of S_SHOW
      step(2);
      check_out("t5_show", 8'hFE, S2);
      Rst = 1'b1;
      step();
      check_out("t5_rst", 8'hFF, 7'h7F);
      check_eq("t5_rst_fd", {31'h0, frame_done}, 32'h0);
      Rst = 1'b0;
      step();
      check_out("t5_resume_guard", 8'hFF, S2);

      // 6. leading-zero handling
      value = 32'h000000A5;
      step(40);
      check_eq("t6_fd", {31'h0, frame_done}, 32'h1);
      check_out("t6_predrive", 8'hFF, S5);
      step();
      check_out("t6_d0", 8'hFE, S5);
      step(5);
      check_out("t6_d1", 8'hFD, SA);
      step(4);
`ifdef SEG7_LZ_BLANK_EN
      check_out("t6_g2", 8'hFF, 7'h7F);
      step();
      check_out("t6_d2", 8'hFF, 7'h7F);
      step(25);
      check_out("t6_d7", 8'hFF, 7'h7F);
`else
      check_out("t6_g2", 8'hFF, S0);
      step();
      check_out("t6_d2", 8'hFB, S0);
      step(25);
      check_out("t6_d7", 8'h7F, S0);
`endif
      value = 32'h00000000;
      step(4);
      check_eq("t6_fd_zero", {31'h0, frame_done}, 32'h1);
      step();
      check_out("t6_zero_d0", 8'hFE, S0);
      step(5);
`ifdef SEG7_LZ_BLANK_EN
      check_out("t6_zero_d1", 8'hFF, 7'h7F);
`else
      check_out("t6_zero_d1", 8'hFD, S0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
